// File: rtl/sel_minmax_pipe_pkg.sv
// ============================================================================
// Module : sel_minmax_pkg
// Brief  : Shared mode encodings and tree-indexing helper for sel_minmax_pipe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sel_minmax_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  localparam bit ACT_HIGH = 1'b1;

  // Heap-numbered node (root = 1) to its pipeline level: leaves' parents are
  // level 1, the root is level DEPTH.
  function automatic int tree_level(input int node, input int depth);
    return depth - $clog2(node + 1) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin_dec.sv
// ============================================================================
// Module : bin_dec
// Brief  : Binary index to one-hot decoder with selectable active level.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bin_dec #(
  parameter int IW  = 3,
  parameter int OW  = 8,
  parameter bit ACT = 1'b1
) (
  input  logic [IW-1:0] bin,
  input  logic          en,
  output logic [OW-1:0] vec
);

  for (genvar i = 0; i < OW; i++) begin : g_bit
    assign vec[i] = (en && (bin == IW'(i))) ? ACT : ~ACT;
  end

endmodule

`default_nettype wire

// File: rtl/sel_minmax_pipe_node.sv
// ============================================================================
// Module : minmax_node
// Brief  : Combinational two-candidate min/max compare; ties keep side a.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module minmax_node
  import sel_minmax_pkg::*;
#(
  parameter int IW     = 3,
  parameter int DW     = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             mode,
  input  logic [IW+DW:0]   a,
  input  logic [IW+DW:0]   b,
  output logic [IW+DW:0]   y
);

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } cand_t;

  cand_t ca;
  cand_t cb;
  logic  w_a_ge;
  logic  w_a_le;
  logic  w_pick_a;

  assign ca = a;
  assign cb = b;

  if (SIGNED) begin : g_signed
    assign w_a_ge = $signed(ca.data) >= $signed(cb.data);
    assign w_a_le = $signed(ca.data) <= $signed(cb.data);
  end else begin : g_unsigned
    assign w_a_ge = ca.data >= cb.data;
    assign w_a_le = ca.data <= cb.data;
  end

  // a is always the lower-index side, so the inclusive compares give ties to it
  assign w_pick_a = (mode == MODE_MAX) ? w_a_ge : w_a_le;

  always_comb begin
    y = '0;
    if (ca.vld && cb.vld) begin
      y = w_pick_a ? a : b;
    end else if (ca.vld) begin
      y = a;
    end else if (cb.vld) begin
      y = b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sel_minmax_pipe.sv
// ============================================================================
// Module : sel_minmax_pipe
// Brief  : Pipelined valid/ready min/max selector, one tree level per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sel_minmax_pipe
  import sel_minmax_pkg::*;
#(
  parameter int  IN     = 8,
  parameter int  DATA   = 8,
  parameter bit  SIGNED = 1'b0,
  parameter bit  ACT    = ACT_HIGH,
  localparam int OUT    = $clog2(IN)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [IN-1:0]            in_mask,
  input  logic [IN-1:0][DATA-1:0]  in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA-1:0]          out,
  output logic [OUT-1:0]           out_idx,
  output logic [IN-1:0]            out_vec,
  output logic                     out_none
);

  localparam int EIN = 1 << OUT;

  typedef struct packed {
    logic            vld;
    logic [OUT-1:0]  idx;
    logic [DATA-1:0] data;
  } cand_t;

  // Heap numbering: node n combines children 2n (lower indices) and 2n+1
  cand_t leaf    [EIN];
  cand_t node_d  [1:EIN-1];
  cand_t node_q  [1:EIN-1];
  logic  node_en [1:EIN-1];

  logic  r_vld  [1:OUT];
  logic  r_mode [1:OUT];
  logic  w_vin  [1:OUT];
  logic  w_mode [1:OUT];
  logic  w_stall;
  cand_t root;

  assign w_stall  = r_vld[OUT] & ~out_ready;
  assign in_ready = ~w_stall;

  for (genvar i = 0; i < EIN; i++) begin : g_leaf
    if (i < IN) begin : g_real
      assign leaf[i] = cand_t'{vld: in_mask[i], idx: OUT'(i), data: in[i]};
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  always_comb begin
    w_vin[1]  = in_valid;
    w_mode[1] = in_mode;
    for (int k = 2; k <= OUT; k++) begin
      w_vin[k]  = r_vld[k-1];
      w_mode[k] = r_mode[k-1];
    end
  end

  for (genvar n = 1; n < EIN; n++) begin : g_node
    localparam int LVL = tree_level(n, OUT);
    cand_t a;
    cand_t b;

    if (2 * n >= EIN) begin : g_from_leaf
      assign a = leaf[2*n - EIN];
      assign b = leaf[2*n + 1 - EIN];
    end else begin : g_from_node
      assign a = node_q[2*n];
      assign b = node_q[2*n + 1];
    end

    minmax_node #(
      .IW     (OUT),
      .DW     (DATA),
      .SIGNED (SIGNED)
    ) u_node (
      .mode (w_mode[LVL]),
      .a    (a),
      .b    (b),
      .y    (node_d[n])
    );

    assign node_en[n] = w_vin[LVL];
  end

  // Valids advance on every unstalled cycle; candidate registers only
  // capture when a real transaction reaches their level.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int k = 1; k <= OUT; k++) begin
        r_vld[k]  <= 1'b0;
        r_mode[k] <= MODE_MAX;
      end
      for (int n = 1; n < EIN; n++) begin
        node_q[n] <= '0;
      end
    end else if (!w_stall) begin
      for (int k = 1; k <= OUT; k++) begin
        r_vld[k] <= w_vin[k];
        if (w_vin[k]) begin
          r_mode[k] <= w_mode[k];
        end
      end
      for (int n = 1; n < EIN; n++) begin
        if (node_en[n]) begin
          node_q[n] <= node_d[n];
        end
      end
    end
  end

  assign root      = node_q[1];
  assign out_valid = r_vld[OUT];
  assign out       = root.data;
  assign out_idx   = root.idx;
  assign out_none  = r_vld[OUT] & ~root.vld;

  bin_dec #(
    .IW  (OUT),
    .OW  (IN),
    .ACT (ACT)
  ) u_dec (
    .bin (root.idx),
    .en  (root.vld),
    .vec (out_vec)
  );

endmodule

`default_nettype wire
